// File: rtl/fwd_pkg.sv
// Shared types and constants for the ID-stage branch forwarding and hazard unit.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_MUL = 2'b11
  } fwd_sel_e;

  // Wide enough for any register-address width; slice to REG_AW at the use site.
  localparam logic [31:0] REG_ZERO = '0;

endpackage

// File: rtl/mul_scoreboard.sv
// Multiplier scoreboard: per-register pending bits, outstanding-multiply count,
// full and WAW detection for a multiply waiting in ID.
module mul_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   done,
  input  logic [REG_AW-1:0]      done_rd,
  input  logic [REG_AW-1:0]      chk_rd,
  output logic [(1<<REG_AW)-1:0] pending,
  output logic                   full,
  output logic                   waw
);

  localparam int unsigned CW = $clog2(MUL_MAX + 1);

  logic [(1<<REG_AW)-1:0] pending_d;
  logic [CW-1:0]          mul_cnt, mul_cnt_d;
  logic                   inc, dec;

  // Clear first so that a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending;
    if (done) pending_d[done_rd] = 1'b0;
    if (issue && issue_rd != REG_ZERO[REG_AW-1:0]) pending_d[issue_rd] = 1'b1;
  end

  assign inc = issue;
  assign dec = done && (mul_cnt != '0);

  always_comb begin
    mul_cnt_d = mul_cnt;
    if (inc && !dec)      mul_cnt_d = mul_cnt + CW'(1);
    else if (dec && !inc) mul_cnt_d = mul_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mul_cnt <= '0;
    end else begin
      pending <= pending_d;
      mul_cnt <= mul_cnt_d;
    end
  end

  assign full = (mul_cnt == CW'(MUL_MAX)) && !done;
  assign waw  = pending[chk_rd] && (chk_rd != REG_ZERO[REG_AW-1:0]) &&
                !(done && done_rd == chk_rd);

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// ID-stage operand forwarding, stall generation and stall watchdog for early branches.
// Optional FWD_STALL_STATS_EN adds a saturating stall_cycles counter output.
module branch_fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned MUL_MAX   = 4,
  parameter int unsigned STALL_TMO = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic                      id_branch,
  input  logic                      id_is_mul,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      ex_issue,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         m_rd,
  input  logic                      m_regwrite,
  input  logic                      m_is_load,
  input  logic [REG_AW-1:0]         w_rd,
  input  logic                      w_regwrite,
  input  logic                      mul_done,
  input  logic [REG_AW-1:0]         mul_rd,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      hazard_err
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int unsigned TW = $clog2(STALL_TMO) + 1;

  logic [(1<<REG_AW)-1:0] pending;
  logic                   mul_full, mul_waw, mul_stall;
  logic [NUM_SRC-1:0]     chan_stall;
  logic [TW-1:0]          tmo_cnt;
  logic                   unused_ex_load;

  assign unused_ex_load = ex_is_load;

  mul_scoreboard #(
    .REG_AW  (REG_AW),
    .MUL_MAX (MUL_MAX)
  ) u_mul_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue    (ex_issue && id_is_mul),
    .issue_rd (id_rd),
    .done     (mul_done),
    .done_rd  (mul_rd),
    .chk_rd   (id_rd),
    .pending  (pending),
    .full     (mul_full),
    .waw      (mul_waw)
  );

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_chan
    logic [REG_AW-1:0] rs;
    logic              live;
    fwd_sel_e          sel;

    assign rs   = id_rs[k*REG_AW +: REG_AW];
    assign live = id_valid && id_branch && id_rs_used[k] && (rs != REG_ZERO[REG_AW-1:0]);

    always_comb begin
      sel = FWD_RF;
      if (live) begin
        if (m_regwrite && !m_is_load && m_rd == rs) sel = FWD_MEM;
        else if (mul_done && mul_rd == rs)          sel = FWD_MUL;
        else if (w_regwrite && w_rd == rs)          sel = FWD_WB;
      end
    end

    assign chan_stall[k] = live && ((ex_regwrite && ex_rd == rs) ||
                                    (m_regwrite && m_is_load && m_rd == rs) ||
                                    (pending[rs] && !(mul_done && mul_rd == rs)));
    assign fwd_sel[2*k +: 2] = reset ? 2'b00 : sel;
  end

  assign mul_stall = id_valid && id_is_mul && (mul_full || mul_waw);
  assign stall     = !reset && ((|chan_stall) || mul_stall);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt    <= '0;
      hazard_err <= 1'b0;
    end else begin
      if (!stall)                            tmo_cnt <= '0;
      else if (tmo_cnt != TW'(STALL_TMO - 1)) tmo_cnt <= tmo_cnt + TW'(1);
      if (stall && tmo_cnt == TW'(STALL_TMO - 1)) hazard_err <= 1'b1;
    end
  end

`ifdef FWD_STALL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     stall_cycles <= '0;
    else if (stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Directed self-checking bench for branch_fwd_scoreboard (default parameters).
module tb_branch_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_branch, id_is_mul;
  logic [4:0]  id_rd;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        ex_issue;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_is_load;
  logic [4:0]  m_rd;
  logic        m_regwrite, m_is_load;
  logic [4:0]  w_rd;
  logic        w_regwrite;
  logic        mul_done;
  logic [4:0]  mul_rd;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        hazard_err;
`ifdef FWD_STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_fwd_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_branch   (id_branch),
    .id_is_mul   (id_is_mul),
    .id_rd       (id_rd),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .ex_issue    (ex_issue),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .ex_is_load  (ex_is_load),
    .m_rd        (m_rd),
    .m_regwrite  (m_regwrite),
    .m_is_load   (m_is_load),
    .w_rd        (w_rd),
    .w_regwrite  (w_regwrite),
    .mul_done    (mul_done),
    .mul_rd      (mul_rd),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .hazard_err  (hazard_err)
`ifdef FWD_STALL_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_valid = 0; id_branch = 0; id_is_mul = 0; id_rd = 0; id_rs = 0; id_rs_used = 0;
    ex_issue = 0; ex_rd = 0; ex_regwrite = 0; ex_is_load = 0;
    m_rd = 0; m_regwrite = 0; m_is_load = 0; w_rd = 0; w_regwrite = 0;
    mul_done = 0; mul_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used);
    id_valid = 1; id_branch = 1; id_rs = {rs2, rs1}; id_rs_used = used;
  endtask

  task automatic mul_issue(input logic [4:0] rd);
    clr(); id_valid = 1; id_is_mul = 1; id_rd = rd; ex_issue = 1;
    tick();
  endtask

  initial begin
    clr();
    reset = 1;
    #3;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_err", 32'(hazard_err), 0);
    #9 reset = 0;
    tick();

    // 1: MEM beats WB, then WB alone
    branch(5'd5, 5'd0, 2'b01); m_rd = 5; m_regwrite = 1; w_rd = 5; w_regwrite = 1; #1;
    check("t1_fwd_mem", 32'(fwd_sel), 32'h1);
    check("t1_stall", 32'(stall), 0);
    m_regwrite = 0; #1;
    check("t1_fwd_wb", 32'(fwd_sel), 32'h2);

    // 2: EX writer stalls, then forwards from MEM; load in MEM stalls
    clr(); branch(5'd0, 5'd7, 2'b10); ex_rd = 7; ex_regwrite = 1; #1;
    check("t2_ex_stall", 32'(stall), 1);
    check("t2_ex_fwd", 32'(fwd_sel), 0);
    tick();
    ex_regwrite = 0; m_rd = 7; m_regwrite = 1; #1;
    check("t2_mem_stall", 32'(stall), 0);
    check("t2_mem_fwd", 32'(fwd_sel), 32'h4);
    m_is_load = 1; #1;
    check("t2_load_stall", 32'(stall), 1);
    check("t2_load_fwd", 32'(fwd_sel), 0);
    clr(); tick();

    // 5a: x0, unused channel, non-branch never forward or stall
    branch(5'd0, 5'd0, 2'b11); m_rd = 0; m_regwrite = 1; ex_rd = 0; ex_regwrite = 1; #1;
    check("x0_fwd", 32'(fwd_sel), 0);
    check("x0_stall", 32'(stall), 0);
    clr(); branch(5'd5, 5'd0, 2'b00); m_rd = 5; m_regwrite = 1; #1;
    check("unused_fwd", 32'(fwd_sel), 0);
    clr(); id_valid = 1; id_rs = {5'd0, 5'd6}; id_rs_used = 2'b01; ex_rd = 6; ex_regwrite = 1; #1;
    check("nonbranch_stall", 32'(stall), 0);
    clr(); tick();

    // 3: mul to x9, branch waits for mul_done
    mul_issue(5'd9);
    clr(); branch(5'd9, 5'd0, 2'b01); #1;
    check("t3_pend_stall", 32'(stall), 1);
    tick();
    check("t3_pend_stall2", 32'(stall), 1);
    mul_done = 1; mul_rd = 9; #1;
    check("t3_done_fwd", 32'(fwd_sel), 32'h3);
    check("t3_done_stall", 32'(stall), 0);
    tick();
    mul_done = 0; #1;
    check("t3_cleared", 32'(stall), 0);
    check("t3_cleared_fwd", 32'(fwd_sel), 0);

    // WAW on a pending destination
    mul_issue(5'd3);
    clr(); id_valid = 1; id_is_mul = 1; id_rd = 3; #1;
    check("waw_stall", 32'(stall), 1);
    mul_done = 1; mul_rd = 3; #1;
    check("waw_done", 32'(stall), 0);
    tick();
    clr(); tick();

    // 4: fill to MUL_MAX, full stall, simultaneous issue+done keeps count
    mul_issue(5'd10); mul_issue(5'd11); mul_issue(5'd12); mul_issue(5'd13);
    clr(); id_valid = 1; id_is_mul = 1; id_rd = 14; #1;
    check("t4_full", 32'(stall), 1);
    mul_done = 1; mul_rd = 10; #1;
    check("t4_full_done", 32'(stall), 0);
    ex_issue = 1; tick();
    clr(); id_valid = 1; id_is_mul = 1; id_rd = 15; #1;
    check("t4_still_full", 32'(stall), 1);
    clr(); branch(5'd10, 5'd0, 2'b01); #1;
    check("t4_x10_clear", 32'(stall), 0);
    clr(); branch(5'd14, 5'd0, 2'b01); #1;
    check("t4_x14_pend", 32'(stall), 1);
    // same-register set and clear: set wins
    clr(); id_valid = 1; id_is_mul = 1; id_rd = 11; ex_issue = 1; mul_done = 1; mul_rd = 11;
    tick();
    clr(); branch(5'd11, 5'd0, 2'b01); #1;
    check("t4_set_wins", 32'(stall), 1);

    // 5b: async reset mid-stall
    clr(); branch(5'd14, 5'd0, 2'b01); #1;
    check("t5_pre_rst", 32'(stall), 1);
    reset = 1; #1;
    check("t5_rst_stall", 32'(stall), 0);
    check("t5_rst_fwd", 32'(fwd_sel), 0);
    #1 reset = 0; #1;
    check("t5_pend_clr", 32'(stall), 0);
    clr(); id_valid = 1; id_is_mul = 1; id_rd = 15; #1;
    check("t5_cnt_clr", 32'(stall), 0);

    // 6: watchdog after 64 stall cycles, sticky
    clr(); branch(5'd4, 5'd0, 2'b01); m_rd = 4; m_regwrite = 1; m_is_load = 1;
    for (int i = 0; i < 63; i++) tick();
    check("t6_err_63", 32'(hazard_err), 0);
    tick();
    check("t6_err_64", 32'(hazard_err), 1);
    clr(); tick();
    check("t6_no_stall", 32'(stall), 0);
    check("t6_sticky", 32'(hazard_err), 1);
`ifdef FWD_STALL_STATS_EN
    check("t6_stall_cycles", stall_cycles, 32'd64);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
